// File: rtl/note_detector.sv
// note_detector: measures the period of tone_i and classifies it against a fixed note table.
// Latency: outputs update 3 clk after the tone_i rising edge that completes a period (5 with glitch filter).
// Backpressure: none; free-running, results are presented as registered levels and a one-cycle pulse.
//
// Ports:
//   clk, rst_l      clock, asynchronous active-low reset
//   enable_i        low forces IDLE and clears all outputs (no change pulse)
//   tone_i          asynchronous square-wave tone input
//   note_idx_o      locked note index (table order)
//   note_valid_o    high while a note is locked
//   note_change_o   one-cycle pulse when the locked index/valid takes a new value
//   period_o        last measured period in clk cycles (T_OUT after a timeout)
//   led_o           note_idx_o+1 while valid, else 0
//
// Optional: define NOTE_DET_GLITCH_FILTER_EN to insert a 3-tap majority filter after the
// synchroniser; single-cycle glitches are rejected at the cost of 2 extra cycles of latency.
module note_detector #(
   parameter int unsigned CLK_REF               = 50_000_000,
   parameter int unsigned NOTE_MIN              = 21,
   parameter int unsigned NUM_NOTES             = 7,
   parameter int unsigned NOTE_TABLE [NUM_NOTES] = '{262, 294, 330, 349, 392, 440, 494},
   parameter int unsigned TOL_SHIFT             = 5,
   parameter int unsigned LOCK_CNT              = 4,
   parameter int unsigned IW                    = $clog2(NUM_NOTES),
   parameter int unsigned PW                    = $clog2(CLK_REF / NOTE_MIN) + 1
) (
   input  logic          clk,
   input  logic          rst_l,
   input  logic          enable_i,
   input  logic          tone_i,
   output logic [IW-1:0] note_idx_o,
   output logic          note_valid_o,
   output logic          note_change_o,
   output logic [PW-1:0] period_o,
   output logic [3:0]    led_o
);

   localparam int unsigned   T_OUT   = CLK_REF / NOTE_MIN;
   localparam logic [PW-1:0] T_OUT_P = PW'(T_OUT);
   localparam int unsigned   CW      = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] LOCK_P  = CW'(LOCK_CNT);

   typedef enum logic [1:0] {IDLE, ARM, TRACK} state_t;

   state_t          state;
   logic [PW-1:0]   cnt;
   logic [IW-1:0]   cand;
   logic [CW-1:0]   mcnt;
   logic [CW-1:0]   miss_cnt;

   // ------------------------------------------------------------------
   // Input synchroniser, optional majority filter, rising-edge detect
   // ------------------------------------------------------------------
   logic tone_s1, tone_s2, tone_f, tone_d, rise;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         tone_s1 <= 1'b0;
         tone_s2 <= 1'b0;
      end else begin
         tone_s1 <= tone_i;
         tone_s2 <= tone_s1;
      end
   end

`ifdef NOTE_DET_GLITCH_FILTER_EN
   logic [2:0] tone_sh;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) tone_sh <= 3'b000;
      else        tone_sh <= {tone_sh[1:0], tone_s2};
   end

   // Two of the last three samples must agree, so a lone 1-cycle blip never flips the output.
   assign tone_f = (tone_sh[0] & tone_sh[1]) | (tone_sh[0] & tone_sh[2]) | (tone_sh[1] & tone_sh[2]);
`else
   assign tone_f = tone_s2;
`endif

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) tone_d <= 1'b0;
      else        tone_d <= tone_f;
   end

   assign rise = tone_f & ~tone_d;

   // ------------------------------------------------------------------
   // Period classification: window per note is [P_n - tol, P_n + tol],
   // all bounds fixed at elaboration.
   // ------------------------------------------------------------------
   logic [NUM_NOTES-1:0] hit;

   for (genvar g = 0; g < NUM_NOTES; g++) begin : g_note
      localparam int unsigned   PN  = CLK_REF / NOTE_TABLE[g];
      localparam int unsigned   TOL = PN >> TOL_SHIFT;
      localparam logic [PW-1:0] LO  = PW'(PN - TOL);
      localparam logic [PW-1:0] HI  = PW'(PN + TOL);
      assign hit[g] = (cnt >= LO) && (cnt <= HI);
   end

   logic          match_any;
   logic [IW-1:0] match_idx;

   // Lowest index wins where windows overlap: scan downwards so the last hit kept is the lowest.
   always_comb begin
      match_any = |hit;
      match_idx = '0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         if (hit[i]) match_idx = IW'(i);
      end
   end

   // ------------------------------------------------------------------
   // Candidate / run-length bookkeeping for the period being completed
   // ------------------------------------------------------------------
   logic [IW-1:0] cand_nx;
   logic [CW-1:0] mcnt_nx, miss_nx;
   logic          do_lock, do_unlock;

   always_comb begin
      cand_nx = cand;
      mcnt_nx = mcnt;
      miss_nx = miss_cnt;
      if (match_any) begin
         miss_nx = '0;
         if (match_idx == cand) begin
            if (mcnt != LOCK_P) mcnt_nx = mcnt + CW'(1);
         end else begin
            cand_nx = match_idx;
            mcnt_nx = CW'(1);
         end
      end else begin
         mcnt_nx = '0;
         if (miss_cnt != LOCK_P) miss_nx = miss_cnt + CW'(1);
      end
      do_lock   = match_any && (mcnt_nx == LOCK_P) && (!note_valid_o || (cand_nx != note_idx_o));
      do_unlock = !match_any && (miss_nx == LOCK_P) && note_valid_o;
   end

   // ------------------------------------------------------------------
   // Main FSM with registered outputs. Rises are at least 2 cycles apart
   // and timeout cannot coincide with a rise-driven event, so the change
   // pulse can never repeat on back-to-back cycles.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state         <= IDLE;
         cnt           <= '0;
         cand          <= '0;
         mcnt          <= '0;
         miss_cnt      <= '0;
         note_idx_o    <= '0;
         note_valid_o  <= 1'b0;
         note_change_o <= 1'b0;
         period_o      <= '0;
         led_o         <= 4'd0;
      end else begin
         note_change_o <= 1'b0;
         if (!enable_i) begin
            state        <= IDLE;
            cnt          <= '0;
            cand         <= '0;
            mcnt         <= '0;
            miss_cnt     <= '0;
            note_idx_o   <= '0;
            note_valid_o <= 1'b0;
            period_o     <= '0;
            led_o        <= 4'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (rise) begin
                     state <= ARM;
                     cnt   <= PW'(1);
                  end
               end
               ARM, TRACK: begin
                  // A rise in the same cycle as the timeout count is a valid period.
                  if (rise) begin
                     state    <= TRACK;
                     cnt      <= PW'(1);
                     period_o <= cnt;
                     cand     <= cand_nx;
                     mcnt     <= mcnt_nx;
                     miss_cnt <= miss_nx;
                     if (do_lock) begin
                        note_idx_o    <= cand_nx;
                        note_valid_o  <= 1'b1;
                        note_change_o <= 1'b1;
                        led_o         <= 4'(cand_nx) + 4'd1;
                     end else if (do_unlock) begin
                        note_valid_o  <= 1'b0;
                        note_change_o <= 1'b1;
                        led_o         <= 4'd0;
                     end
                  end else if (cnt == T_OUT_P) begin
                     // Silence: index is kept, only validity drops.
                     state         <= IDLE;
                     cnt           <= '0;
                     cand          <= '0;
                     mcnt          <= '0;
                     miss_cnt      <= '0;
                     note_valid_o  <= 1'b0;
                     note_change_o <= note_valid_o;
                     period_o      <= T_OUT_P;
                     led_o         <= 4'd0;
                  end else begin
                     cnt <= cnt + PW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: directed tones against a reference model of the note detector.
// Latency: model compares every cycle; stimulus changes on the falling clock edge.
// Backpressure: none.
module tb_note_detector;

   localparam int CLK_REF  = 50_000;
   localparam int NOTE_MIN = 21;
   localparam int T_OUT    = CLK_REF / NOTE_MIN;      // 2380
   localparam int IW       = 3;
   localparam int PW       = $clog2(T_OUT) + 1;       // 13
   localparam int LOCK     = 4;
   localparam int TOLS     = 5;
   localparam int FREQ [7] = '{262, 294, 330, 349, 392, 440, 494};

   logic          clk;
   logic          rst_l;
   logic          enable_i;
   logic          tone_i;
   logic [IW-1:0] note_idx_o;
   logic          note_valid_o;
   logic          note_change_o;
   logic [PW-1:0] period_o;
   logic [3:0]    led_o;

   note_detector #(
      .CLK_REF  (CLK_REF),
      .NOTE_MIN (NOTE_MIN)
   ) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .enable_i      (enable_i),
      .tone_i        (tone_i),
      .note_idx_o    (note_idx_o),
      .note_valid_o  (note_valid_o),
      .note_change_o (note_change_o),
      .period_o      (period_o),
      .led_o         (led_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int pulses   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: tone samples -> effective edges -> period list ->
   // "last LOCK results identical" decides lock / unlock.
   // ------------------------------------------------------------------
   bit hist [7];
   bit m_armed;
   int m_since;
   int m_res[$];
   int m_idx;
   bit m_valid;
   bit m_change;
   int m_period;

   function automatic bit eff(input int j);
`ifdef NOTE_DET_GLITCH_FILTER_EN
      int s;
      s = int'(hist[j+3]) + int'(hist[j+4]) + int'(hist[j+5]);
      return s >= 2;
`else
      return hist[j+2];
`endif
   endfunction

   function automatic int classify(input int p);
      for (int n = 0; n < 7; n++) begin
         int pn, tol, d;
         pn  = CLK_REF / FREQ[n];
         tol = pn >> TOLS;
         d   = p - pn;
         if (d < 0) d = -d;
         if (d <= tol) return n;
      end
      return -1;
   endfunction

   function automatic bit all_same();
      if (m_res.size() != LOCK) return 1'b0;
      foreach (m_res[i]) if (m_res[i] != m_res[0]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      m_armed = 1'b0;
      m_since = 0;
      m_res.delete();
   endtask

   task automatic model_reset();
      foreach (hist[j]) hist[j] = 1'b0;
      model_clear();
      m_idx = 0; m_valid = 1'b0; m_change = 1'b0; m_period = 0;
   endtask

   task automatic model_step();
      bit r_edge;
      int r;
      for (int j = 6; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = tone_i;
      r_edge  = eff(0) && !eff(1);
      m_change = 1'b0;
      if (!enable_i) begin
         model_clear();
         m_idx = 0; m_valid = 1'b0; m_period = 0;
      end else if (m_armed) begin
         m_since++;
         if (r_edge) begin
            m_period = m_since;
            m_since  = 0;
            r = classify(m_period);
            m_res.push_back(r);
            if (m_res.size() > LOCK) void'(m_res.pop_front());
            if (all_same()) begin
               if (r >= 0 && (!m_valid || r != m_idx)) begin
                  m_idx = r; m_valid = 1'b1; m_change = 1'b1;
               end else if (r < 0 && m_valid) begin
                  m_valid = 1'b0; m_change = 1'b1;
               end
            end
         end else if (m_since == T_OUT) begin
            m_change = m_valid;
            m_valid  = 1'b0;
            m_period = T_OUT;
            model_clear();
         end
      end else if (r_edge) begin
         m_armed = 1'b1;
         m_since = 0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_l) model_reset();
         else        model_step();
      end
   end

   // Per-cycle comparison against the model, plus a pulse counter.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_l) begin
            check("cyc_idx",    int'(note_idx_o),    m_idx);
            check("cyc_valid",  int'(note_valid_o),  int'(m_valid));
            check("cyc_change", int'(note_change_o), int'(m_change));
            check("cyc_period", int'(period_o),      m_period);
            check("cyc_led",    int'(led_o),         m_valid ? m_idx + 1 : 0);
            if (note_change_o) pulses++;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic tone_periods(input int p, input int n);
      for (int i = 0; i < n; i++) begin
         tone_i = 1'b1;
         repeat (p / 2) @(negedge clk);
         tone_i = 1'b0;
         repeat (p - p / 2) @(negedge clk);
      end
   endtask

   // Same as tone_periods with a 1-cycle high blip in the middle of each low phase.
   task automatic glitch_periods(input int p, input int n);
      int lo;
      lo = p - p / 2;
      for (int i = 0; i < n; i++) begin
         tone_i = 1'b1;
         repeat (p / 2) @(negedge clk);
         tone_i = 1'b0;
         repeat (lo / 2) @(negedge clk);
         tone_i = 1'b1;
         @(negedge clk);
         tone_i = 1'b0;
         repeat (lo - lo / 2 - 1) @(negedge clk);
      end
   endtask

   task automatic idle_low(input int n);
      tone_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   int p0;

   initial begin
      rst_l    = 1'b0;
      enable_i = 1'b1;
      tone_i   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_idx",    int'(note_idx_o),    0);
      check("rst_valid",  int'(note_valid_o),  0);
      check("rst_change", int'(note_change_o), 0);
      check("rst_period", int'(period_o),      0);
      check("rst_led",    int'(led_o),         0);
      rst_l = 1'b1;
      repeat (2) @(negedge clk);

      // 440 Hz -> P=113, lock on the 5th rising edge
      p0 = pulses;
      tone_periods(113, 4);
      check("a440_unlocked_4_edges", int'(note_valid_o), 0);
      tone_periods(113, 2);
      check("a440_idx",    int'(note_idx_o),   5);
      check("a440_valid",  int'(note_valid_o), 1);
      check("a440_led",    int'(led_o),        6);
      check("a440_period", int'(period_o),     113);
      check("a440_pulses", pulses - p0,        1);

      // switch to 330 Hz -> P=151
      p0 = pulses;
      tone_periods(151, 4);
      check("e330_hold_idx", int'(note_idx_o), 5);
      tone_periods(151, 2);
      check("e330_idx",    int'(note_idx_o), 2);
      check("e330_led",    int'(led_o),      3);
      check("e330_period", int'(period_o),   151);
      check("e330_pulses", pulses - p0,      1);

      // 262 Hz -> P=190, then silence until timeout
      p0 = pulses;
      tone_periods(190, 6);
      check("c262_led", int'(led_o), 1);
      idle_low(T_OUT);
      check("tmo_valid",  int'(note_valid_o), 0);
      check("tmo_led",    int'(led_o),        0);
      check("tmo_period", int'(period_o),     2380);
      check("tmo_pulses", pulses - p0,        2);

      // 415 Hz -> P=120, falls between the 440 and 392 windows
      p0 = pulses;
      tone_periods(120, 8);
      check("f415_valid",  int'(note_valid_o), 0);
      check("f415_period", int'(period_o),     120);
      check("f415_pulses", pulses - p0,        0);

      // 494 Hz -> P=101
      p0 = pulses;
      tone_periods(101, 6);
      check("b494_idx",    int'(note_idx_o), 6);
      check("b494_led",    int'(led_o),      7);
      check("b494_pulses", pulses - p0,      1);

      // one-cycle enable drop, then relock needing 5 edges
      p0 = pulses;
      enable_i = 1'b0;
      @(negedge clk);
      check("en_valid",  int'(note_valid_o), 0);
      check("en_idx",    int'(note_idx_o),   0);
      check("en_led",    int'(led_o),        0);
      check("en_period", int'(period_o),     0);
      enable_i = 1'b1;
      tone_periods(101, 4);
      check("en_unlocked_4_edges", int'(note_valid_o), 0);
      tone_periods(101, 2);
      check("en_relock_idx", int'(note_idx_o), 6);
      check("en_pulses",     pulses - p0,      1);

      // 440 Hz with a 1-cycle blip in every low phase
      p0 = pulses;
      glitch_periods(113, 10);
`ifdef NOTE_DET_GLITCH_FILTER_EN
      check("glitch_valid", int'(note_valid_o), 1);
      check("glitch_idx",   int'(note_idx_o),   5);
`else
      check("glitch_valid", int'(note_valid_o), 0);
`endif
      check("glitch_pulses", pulses - p0, 1);

      // period exactly T_OUT: the edge must win over the timeout
      idle_low(T_OUT + 10);
      tone_periods(T_OUT, 1);
      tone_periods(113, 2);
      check("edge_wins_period", int'(period_o), 113);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
